cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint sequencer for the 4-state (IF,FD,EX,RWB) 8-bit CPU core.
//  Issues a one-cycle clock-enable (cpu_ce) to the core per micro-state advance, derived from a free-running
//  tick divider; supports free-run, single-instruction step via debounced pushbutton, PC breakpoint and halt
//  on opcode F. Sits between the board clock/switches and the core; all in one 50 MHz domain.
// PARAMETERS
//  DIV        50000   clk cycles per run tick (tick = 1 cycle pulse every DIV cycles)
//  DEB_CYCLES 500000  cycles the synchronised key must be stable before debounced level changes
//  CNT_W      16      width of instr_count
// PORTS
//  clk          in   1      system clock; single clock domain
//  reset_n      in   1      asynchronous, active-low reset
//  mode_step    in   1      0 = free-run requested, 1 = single-step requested (slide switch, static)
//  step_key_n   in   1      raw pushbutton, active-low, asynchronous/bouncy
//  cpu_state    in   2      core micro-state: 00 IF, 01 FD, 10 EX, 11 RWB
//  opcode       in   4      core IR[15:12]
//  pc           in   8      core program counter
//  bp_en        in   1      breakpoint enable
//  bp_addr      in   8      breakpoint PC
//  cpu_ce       out  1      core advances one micro-state on a clk edge where cpu_ce=1
//  ctrl_state   out  2      00 PAUSE, 01 RUN, 10 STEP, 11 HALT
//  halted       out  1      1 while ctrl_state==HALT
//  bp_hit       out  1      1 while paused due to breakpoint
//  instr_count  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (reset_n=0, async): ctrl_state=RUN, cpu_ce=0, halted=0, bp_hit=0, instr_count=0, tick counter=0,
//   debounced key=released(1), skip=0. All registers except cpu_ce; cpu_ce is combinational from registered
//   state, tick and inputs (zero latency).
//  Tick: counter 0..DIV-1, tick=1 when counter==DIV-1, then wraps to 0; runs in every ctrl_state.
//  Key: 2-FF synchroniser; stability counter clears whenever sync==debounced, else increments; when it reaches
//   DEB_CYCLES-1 debounced<=sync. press = 1-cycle pulse on debounced 1->0. Release generates nothing.
//  Boundary = tick && cpu_state==IF. Retire = cpu_ce && cpu_state==RWB.
//  RUN: on boundary, stop if mode_step==1 OR (bp_en && pc==bp_addr && !skip): cpu_ce=0, ->PAUSE,
//   bp_hit<=breakpoint term (both true -> bp_hit=1). Otherwise cpu_ce=tick. Breakpoint/mode checked only at IF.
//  STEP: cpu_ce=tick; breakpoints ignored; after retire ->PAUSE (exactly 4 ce pulses per step from IF).
//  PAUSE: cpu_ce=0. press && mode_step==0 -> RUN; press && mode_step==1 -> STEP. Leaving PAUSE: bp_hit<=0, skip<=1.
//  skip clears on first retire, so resuming at a breakpoint PC executes that instruction once.
//  Retire with opcode==4'hF (any of RUN/STEP) -> HALT, overriding RUN->continue and STEP->PAUSE.
//  HALT: cpu_ce=0, halted=1; press and mode_step ignored; exit only via reset_n.
//  instr_count += 1 on every retire (including the F retire); wraps 2^CNT_W-1 -> 0.
//  press arriving in RUN, STEP or HALT is dropped (not queued).
//  reset_n asserted mid-step/mid-debounce: immediate return to reset values; partial step abandoned.
// TESTING (DIV=4, DEB_CYCLES=8 in bench; core model advances cpu_state on cpu_ce)
//  1 mode_step=0 after reset -> cpu_ce pulses every 4th clk, first ce at clk 4; after 4 ce instr_count=1, state RUN.
//  2 mode_step=1 -> pause at first IF boundary (0 ce); key low 20 clks -> STEP, exactly 4 ce, PAUSE,
//    instr_count+1; second press during STEP produces no extra ce.
//  3 key glitches low for 5 clks (<8) repeatedly -> no press, ctrl_state stays PAUSE, cpu_ce never 1.
//  4 bp_en=1 bp_addr=8'h05, run from pc=0 -> PAUSE with pc=05, cpu_state=IF, bp_hit=1; press with
//    mode_step=0 -> bp_hit=0, instruction at 05 executes, run continues (no re-stop at 05).
//  5 opcode=F retires in RUN -> ctrl_state=HALT, halted=1, no further ce for 100 clks despite key presses;
//    instr_count includes the F instruction.
//  6 reset_n pulsed low during STEP after 2 ce -> outputs reset values same cycle, ctrl_state=RUN, count=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the 4-state (IF,FD,EX,RWB) CPU core.
// Gates a one-cycle clock enable per micro-state from a free-running tick,
// with a debounced step key, PC breakpoint and halt on opcode F.
//
// state | meaning
// ------+-------------------------------------------------------------
// PAUSE | core frozen; waiting for a debounced key press
// RUN   | free-run, one micro-state per tick; mode/breakpoint checked at IF
// STEP  | one instruction (4 ticks from IF), then back to PAUSE
// HALT  | opcode F retired; frozen until reset_n
module cpu_run_ctrl #(
    parameter int DIV        = 50000,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode_step,
    input  logic             step_key_n,
    input  logic [1:0]       cpu_state,
    input  logic [3:0]       opcode,
    input  logic [7:0]       pc,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    output logic             cpu_ce,
    output logic [1:0]       ctrl_state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [1:0] CS_IF  = 2'b00;
    localparam logic [1:0] CS_RWB = 2'b11;

    typedef enum logic [1:0] {
        S_PAUSE = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            key_meta, key_sync, key_deb, key_deb_q;
    logic [DW-1:0]   deb_cnt;
    logic            press;
    logic            skip, skip_nxt;
    logic            bp_hit_nxt;
    logic            bp_match;
    logic            boundary;
    logic            ce;
    logic            retire;

    assign tick     = (tick_cnt == TICK_LAST);
    assign boundary = tick && (cpu_state == CS_IF);
    assign bp_match = bp_en && (pc == bp_addr) && !skip;
    assign press    = key_deb_q && !key_deb;

    // Free-running tick divider, independent of controller state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   tick_cnt <= '0;
        else if (tick)  tick_cnt <= '0;
        else            tick_cnt <= tick_cnt + TW'(1);
    end

    // Key synchroniser; idles at released (1) so reset never fakes a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= step_key_n;
            key_sync <= key_meta;
        end
    end

    // Debounce: the synchronised key must disagree with the debounced level
    // for DEB_CYCLES consecutive cycles before the level follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt   <= '0;
            key_deb   <= 1'b1;
            key_deb_q <= 1'b1;
        end else begin
            key_deb_q <= key_deb;
            if (key_sync == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_deb <= key_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // Next-state, clock enable and flag updates.
    always_comb begin
        state_nxt  = state;
        ce         = 1'b0;
        bp_hit_nxt = bp_hit;
        skip_nxt   = skip;
        case (state)
            S_RUN: begin
                if (boundary && (mode_step || bp_match)) begin
                    state_nxt  = S_PAUSE;
                    bp_hit_nxt = bp_match;
                end else begin
                    ce = tick;
                end
            end
            S_STEP: ce = tick;
            S_PAUSE: begin
                if (press) begin
                    state_nxt  = mode_step ? S_STEP : S_RUN;
                    bp_hit_nxt = 1'b0;
                    skip_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
        retire = ce && (cpu_state == CS_RWB);
        // A retire clears the breakpoint skip and may end a step or halt.
        if (retire) begin
            skip_nxt = 1'b0;
            if (opcode == 4'hF)        state_nxt = S_HALT;
            else if (state == S_STEP)  state_nxt = S_PAUSE;
        end
    end

    // Controller state and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_RUN;
            bp_hit <= 1'b0;
            skip   <= 1'b0;
        end else begin
            state  <= state_nxt;
            bp_hit <= bp_hit_nxt;
            skip   <= skip_nxt;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     instr_count <= '0;
        else if (retire)  instr_count <= instr_count + CNT_W'(1);
    end

    assign cpu_ce     = ce;
    assign ctrl_state = state;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: small core model, per-cycle reference model,
// vector table, directed corner sequences and a randomized soak.
module tb_cpu_run_ctrl;

    localparam int DIV   = 4;
    localparam int DEB   = 8;
    localparam int CNT_W = 4;
    localparam int P = 0, R = 1, S = 2, H = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             mode_step = 1'b0;
    logic             step_key_n = 1'b1;
    logic [1:0]       cpu_state = 2'b00;
    logic [3:0]       opcode = 4'h0;
    logic [7:0]       pc = 8'h00;
    logic             bp_en = 1'b0;
    logic [7:0]       bp_addr = 8'h00;
    logic             cpu_ce;
    logic [1:0]       ctrl_state;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] instr_count;

    cpu_run_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .mode_step(mode_step), .step_key_n(step_key_n),
        .cpu_state(cpu_state), .opcode(opcode), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_ce(cpu_ce), .ctrl_state(ctrl_state), .halted(halted), .bp_hit(bp_hit),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int ce_total = 0;
    logic [3:0] prog [256];

    // Reference model state
    int m_state, m_phase, m_cnt;
    bit m_bp, m_skip, m_deb, m_press, m_s1, m_s2;
    bit m_win [DEB];
    int e_ce, n_state;
    bit n_bp, n_skip, e_retire, ce_seen;

    typedef struct {
        bit mode; bit bpe; logic [7:0] bpa; bit hh; logic [7:0] hpc;
        int ncyc; int e_state; int e_cnt; int e_pc; bit e_bp;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = R; m_phase = 0; m_cnt = 0; m_bp = 0; m_skip = 0;
        m_deb = 1; m_press = 0; m_s1 = 1; m_s2 = 1;
        for (int i = 0; i < DEB; i++) m_win[i] = 1;
    endtask

    // Expected enable and next values from the current inputs.
    task automatic model_comb();
        bit tick, brk;
        tick = (m_phase == DIV - 1);
        brk  = bp_en && (pc == bp_addr) && !m_skip;
        e_ce = 0; n_state = m_state; n_bp = m_bp; n_skip = m_skip;
        if (m_state == R) begin
            if (tick && cpu_state == 2'd0 && (mode_step || brk)) begin
                n_state = P; n_bp = brk;
            end else e_ce = tick;
        end else if (m_state == S) begin
            e_ce = tick;
        end else if (m_state == P && m_press) begin
            n_state = mode_step ? S : R; n_bp = 0; n_skip = 1;
        end
        e_retire = (e_ce != 0) && cpu_state == 2'd3;
        if (e_retire) begin
            n_skip = 0;
            if (opcode == 4'hF) n_state = H;
            else if (m_state == S) n_state = P;
        end
    endtask

    // Key level follows once the last DEB synchronised samples all disagree.
    task automatic model_update();
        bit all_diff;
        m_state = n_state; m_bp = n_bp; m_skip = n_skip;
        if (e_retire) m_cnt++;
        m_phase = (m_phase + 1) % DIV;
        for (int i = DEB - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = m_s2;
        all_diff = 1;
        for (int i = 0; i < DEB; i++) if (m_win[i] == m_deb) all_diff = 0;
        m_press = all_diff && m_deb;
        if (all_diff) m_deb = !m_deb;
        m_s2 = m_s1; m_s1 = step_key_n;
    endtask

    // One clock: compare on negedge, advance model and core after posedge.
    task automatic cycle();
        @(negedge clk);
        model_comb();
        chk("cpu_ce", int'(cpu_ce), e_ce);
        chk("ctrl_state", int'(ctrl_state), m_state);
        chk("halted", int'(halted), int'(m_state == H));
        chk("bp_hit", int'(bp_hit), int'(m_bp));
        chk("instr_count", int'(instr_count), m_cnt % (1 << CNT_W));
        ce_seen = cpu_ce;
        if (cpu_ce) ce_total++;
        @(posedge clk);
        #1;
        if (reset_n) begin
            model_update();
            if (ce_seen) begin
                if (cpu_state == 2'd3) pc = pc + 8'd1;
                cpu_state = cpu_state + 2'd1;
            end
        end
        opcode = prog[pc];
    endtask

    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        #1;
        chk("rst_cpu_ce", int'(cpu_ce), 0);
        chk("rst_ctrl_state", int'(ctrl_state), R);
        chk("rst_halted", int'(halted), 0);
        chk("rst_bp_hit", int'(bp_hit), 0);
        chk("rst_instr_count", int'(instr_count), 0);
        model_reset();
        cpu_state = 2'd0; pc = 8'd0; opcode = prog[0]; step_key_n = 1'b1;
        repeat (hold) cycle();
        reset_n = 1'b1;
    endtask

    task automatic press_key(input int low, input int high);
        step_key_n = 1'b0;
        repeat (low) cycle();
        step_key_n = 1'b1;
        repeat (high) cycle();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 4'h0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, key_left;
        clear_prog();
        #2;
        do_reset(3);

        // Vector table: {mode, bp_en, bp_addr, has_halt, halt_pc, cycles, state, count, pc, bp_hit}
        vt[0] = '{0, 0, 8'h00, 0, 8'h00,  40, R, 2,  2, 0};
        vt[1] = '{0, 0, 8'h00, 0, 8'h00,  47, R, 2,  2, 0};
        vt[2] = '{0, 0, 8'h00, 0, 8'h00,  48, R, 3,  3, 0};
        vt[3] = '{1, 0, 8'h00, 0, 8'h00,  40, P, 0,  0, 0};
        vt[4] = '{0, 1, 8'h03, 0, 8'h00, 100, P, 3,  3, 1};
        vt[5] = '{0, 1, 8'h00, 0, 8'h00,  30, P, 0,  0, 1};
        vt[6] = '{0, 0, 8'h00, 1, 8'h02, 100, H, 3,  3, 0};
        vt[7] = '{1, 1, 8'h00, 0, 8'h00,  30, P, 0,  0, 1};
        vt[8] = '{0, 0, 8'h00, 0, 8'h00, 280, R, 1, 17, 0};
        for (int i = 0; i < 9; i++) begin
            clear_prog();
            if (vt[i].hh) prog[vt[i].hpc] = 4'hF;
            mode_step = vt[i].mode; bp_en = vt[i].bpe; bp_addr = vt[i].bpa;
            do_reset(2);
            repeat (vt[i].ncyc) cycle();
            chk($sformatf("vec%0d_state", i), int'(ctrl_state), vt[i].e_state);
            chk($sformatf("vec%0d_count", i), int'(instr_count), vt[i].e_cnt);
            chk($sformatf("vec%0d_pc", i), int'(pc), vt[i].e_pc);
            chk($sformatf("vec%0d_bp_hit", i), int'(bp_hit), int'(vt[i].e_bp));
        end

        // Single step: pause at IF, one press gives exactly 4 enables.
        clear_prog(); mode_step = 1'b1; bp_en = 1'b0;
        do_reset(2);
        repeat (10) cycle();
        chk("step_paused", int'(ctrl_state), P);
        ce_total = 0;
        press_key(20, 40);
        chk("step_ce_count", ce_total, 4);
        chk("step_back_pause", int'(ctrl_state), P);
        chk("step_count", int'(instr_count), 1);
        chk("step_pc", int'(pc), 1);
        chk("step_cpu_state", int'(cpu_state), 0);

        // Reset in the middle of a step after two enables.
        ce_total = 0; guard = 0;
        step_key_n = 1'b0;
        while (ce_total < 2 && guard < 60) begin
            cycle();
            guard++;
        end
        chk("midstep_reached", int'(guard < 60), 1);
        chk("midstep_in_step", int'(ctrl_state), S);
        step_key_n = 1'b1;
        do_reset(3);
        repeat (5) cycle();

        // Short key glitches never produce a press.
        mode_step = 1'b1;
        do_reset(2);
        repeat (10) cycle();
        ce_total = 0;
        repeat (6) press_key(5, 5);
        chk("glitch_ce", ce_total, 0);
        chk("glitch_state", int'(ctrl_state), P);

        // Breakpoint at 05, then resume executes 05 once and keeps running.
        clear_prog(); mode_step = 1'b0; bp_en = 1'b1; bp_addr = 8'h05;
        do_reset(2);
        repeat (100) cycle();
        chk("bp_state", int'(ctrl_state), P);
        chk("bp_pc", int'(pc), 5);
        chk("bp_cpu_state", int'(cpu_state), 0);
        chk("bp_flag", int'(bp_hit), 1);
        chk("bp_count", int'(instr_count), 5);
        press_key(20, 60);
        chk("bp_resume_state", int'(ctrl_state), R);
        chk("bp_resume_flag", int'(bp_hit), 0);
        chk("bp_resume_past", int'(pc >= 8'd6), 1);

        // Halt on F: frozen despite presses and mode changes.
        clear_prog(); prog[1] = 4'hF; bp_en = 1'b0; mode_step = 1'b0;
        do_reset(2);
        repeat (50) cycle();
        chk("halt_state", int'(ctrl_state), H);
        chk("halt_flag", int'(halted), 1);
        chk("halt_count", int'(instr_count), 2);
        ce_total = 0;
        press_key(20, 13);
        mode_step = 1'b1;
        repeat (2) press_key(20, 13);
        chk("halt_ce", ce_total, 0);
        chk("halt_still", int'(ctrl_state), H);
        chk("halt_count_kept", int'(instr_count), 2);

        // Randomized soak against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 256; i++)
                prog[i] = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            bp_en = 1'($urandom_range(0, 1));
            bp_addr = 8'($urandom_range(0, 12));
            mode_step = 1'($urandom_range(0, 1));
            do_reset($urandom_range(1, 3));
            key_left = 0;
            for (int c = 0; c < 600; c++) begin
                if (key_left == 0) begin
                    step_key_n = 1'($urandom_range(0, 1));
                    key_left = $urandom_range(1, 30);
                end
                key_left--;
                if ($urandom_range(0, 149) == 0) mode_step = ~mode_step;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
